// File: rtl/regfile_datapath_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_datapath_n_if
//  Description : Board-side bundle for regfile_datapath_n. Carries the raw
//                buttons and switches into the datapath and the LED slice and
//                busy flag back out.
//                  btnl  raw button: load address register
//                  btnc  raw button: execute (immediate write or ALU op)
//                  btnd  raw button: advance LED slice select
//                  sw    16 switches: address fields, immediate or opcode
//                  led   16-bit slice of operand A
//                  busy  serial shift in progress
//                master = board / stimulus side, slave = datapath side.
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_datapath_n_if;
    logic        btnl;
    logic        btnc;
    logic        btnd;
    logic [15:0] sw;
    logic [15:0] led;
    logic        busy;

    modport master (output btnl, btnc, btnd, sw, input led, busy);
    modport slave  (input btnl, btnc, btnd, sw, output led, busy);
endinterface
`default_nettype wire

// File: rtl/regfile_datapath_n.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_datapath_n
//  Description : NREGS x XLEN register file with a three-field address
//                register, single-cycle ALU, multi-cycle serial shifter and a
//                16-bit LED window onto operand A. Buttons are debounced and
//                turned into one-shot pulses.
//  Ports       : clk   system clock, rising edge
//                btnu  synchronous active-high reset
//                bus   regfile_datapath_n_if.slave (buttons, sw, led, busy)
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_datapath_n #(
    parameter int XLEN          = 32,
    parameter int NREGS         = 32,
    parameter int DEBOUNCE_CLKS = 0
) (
    input  logic                 clk,
    input  logic                 btnu,
    regfile_datapath_n_if.slave  bus
);
    localparam int c_AW   = $clog2(NREGS);
    localparam int c_SHW  = $clog2(XLEN);
    localparam int c_NSL  = XLEN / 16;
    localparam int c_SELW = (c_NSL > 1) ? $clog2(c_NSL) : 1;
    localparam int c_CNTW = (DEBOUNCE_CLKS > 0) ? $clog2(DEBOUNCE_CLKS + 1) : 1;

    localparam logic [c_CNTW-1:0] c_DB_MAX  = c_CNTW'(DEBOUNCE_CLKS);
    localparam logic [c_SELW-1:0] c_SEL_MAX = c_SELW'(c_NSL - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_WB    = 2'd2;

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_LTU = 4'b0011;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_LT  = 4'b0111;
    localparam logic [3:0] c_OP_SRL = 4'b1000;
    localparam logic [3:0] c_OP_SLL = 4'b1001;
    localparam logic [3:0] c_OP_SRA = 4'b1010;
    localparam logic [3:0] c_OP_XOR = 4'b1101;

    // ------------------------------------------------------------------
    // Debounce + one-shot. Bit 0 = btnl, 1 = btnc, 2 = btnd.
    // ------------------------------------------------------------------
    logic [2:0] w_raw;
    logic [2:0] w_deb;
    logic [2:0] r_deb_q;
    logic [2:0] w_pulse;

    assign w_raw = {bus.btnd, bus.btnc, bus.btnl};

    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
        logic [c_CNTW-1:0] r_cnt;
        logic              r_lvl;

        // The counter only runs while raw disagrees with the accepted level;
        // with DEBOUNCE_CLKS = 0 the level simply follows raw each edge.
        always_ff @(posedge clk) begin
            if (btnu) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (w_raw[gi] != r_lvl) begin
                if (r_cnt == c_DB_MAX) begin
                    r_lvl <= w_raw[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNTW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign w_deb[gi] = r_lvl;
    end

    always_ff @(posedge clk) begin
        if (btnu) r_deb_q <= '0;
        else      r_deb_q <= w_deb;
    end

    assign w_pulse = w_deb & ~r_deb_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   r_regs [NREGS];
    logic [c_AW-1:0]   r_rs1, r_rs2, r_rd;
    logic [XLEN-1:0]   r_read_a, r_read_b;
    logic [c_SELW-1:0] r_sel;
    logic [1:0]        r_state;
    logic [XLEN-1:0]   r_sh;
    logic [c_SHW-1:0]  r_cnt;
    logic [1:0]        r_shop;

    logic              w_idle, w_load, w_exec, w_adv;
    logic              w_is_imm, w_is_shift;
    logic [3:0]        w_op;
    logic [XLEN-1:0]   w_imm, w_alu, w_sh_next, w_wdata;
    logic [c_SHW-1:0]  w_k;
    logic              w_we, w_we_eff;

    assign w_idle     = (r_state == S_IDLE);
    assign w_load     = w_pulse[0] & w_idle;
    assign w_exec     = w_pulse[1] & w_idle;
    assign w_adv      = w_pulse[2];
    assign w_op       = bus.sw[3:0];
    assign w_is_imm   = bus.sw[15];
    assign w_imm      = {{(XLEN-15){bus.sw[14]}}, bus.sw[14:0]};
    assign w_k        = r_read_b[c_SHW-1:0];
    assign w_is_shift = !w_is_imm &&
                        (w_op == c_OP_SRL || w_op == c_OP_SLL || w_op == c_OP_SRA);

    always_comb begin
        w_alu = r_read_a + r_read_b;
        case (w_op)
            c_OP_AND: w_alu = r_read_a & r_read_b;
            c_OP_OR:  w_alu = r_read_a | r_read_b;
            c_OP_SUB: w_alu = r_read_a - r_read_b;
            c_OP_XOR: w_alu = r_read_a ^ r_read_b;
            c_OP_LT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(r_read_a) < $signed(r_read_b))};
            c_OP_LTU: w_alu = {{(XLEN-1){1'b0}}, (r_read_a < r_read_b)};
            default:  w_alu = r_read_a + r_read_b;
        endcase
    end

    // Shift type latched at launch: 00 SRL, 01 SLL, 10 SRA (opcode low bits).
    always_comb begin
        case (r_shop)
            2'b01:   w_sh_next = {r_sh[XLEN-2:0], 1'b0};
            2'b10:   w_sh_next = {r_sh[XLEN-1], r_sh[XLEN-1:1]};
            default: w_sh_next = {1'b0, r_sh[XLEN-1:1]};
        endcase
    end

    // Single write port. A zero-length shift writes operand A straight away.
    always_comb begin
        w_we    = 1'b0;
        w_wdata = '0;
        if (r_state == S_WB) begin
            w_we    = 1'b1;
            w_wdata = r_sh;
        end else if (w_exec) begin
            w_we    = !(w_is_shift && (w_k != '0));
            w_wdata = w_is_imm ? w_imm : (w_is_shift ? r_read_a : w_alu);
        end
    end

    // R0 is never written, so it keeps its reset value of zero.
    assign w_we_eff = w_we && (r_rd != '0);

    always_ff @(posedge clk) begin
        if (btnu) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_we_eff) begin
            r_regs[r_rd] <= w_wdata;
        end
    end

    // Operand reads forward a same-edge write so readA/readB never go stale.
    always_ff @(posedge clk) begin
        if (btnu) begin
            r_read_a <= '0;
            r_read_b <= '0;
        end else begin
            r_read_a <= (w_we_eff && r_rs1 == r_rd) ? w_wdata : r_regs[r_rs1];
            r_read_b <= (w_we_eff && r_rs2 == r_rd) ? w_wdata : r_regs[r_rs2];
        end
    end

    always_ff @(posedge clk) begin
        if (btnu) begin
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_rd  <= '0;
            r_sel <= '0;
        end else if (w_load) begin
            r_rs1 <= bus.sw[c_AW-1:0];
            r_rs2 <= bus.sw[5 +: c_AW];
            r_rd  <= bus.sw[10 +: c_AW];
            r_sel <= '0;
        end else if (w_adv) begin
            r_sel <= (r_sel == c_SEL_MAX) ? '0 : r_sel + c_SELW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (btnu) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_shop  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_exec && w_is_shift) begin
                        r_sh   <= r_read_a;
                        r_cnt  <= w_k;
                        r_shop <= w_op[1:0];
                        if (w_k != '0) r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt - c_SHW'(1);
                    if (r_cnt == c_SHW'(1)) r_state <= S_WB;
                end
                S_WB:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [15:0] w_led;

    always_comb begin
        w_led = 16'h0000;
        for (int i = 0; i < c_NSL; i++) begin
            if (r_sel == c_SELW'(i)) w_led = r_read_a[16*i +: 16];
        end
    end

    assign bus.led  = w_led;
    assign bus.busy = !w_idle;

endmodule
`default_nettype wire
